// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared backing-memory port between I-cache refill and D-cache refill/writeback.
// One line transaction in flight at a time. Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LINE_BITS = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic                 i_ack,
    output logic                 i_rvalid,
    output logic [LINE_BITS-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [LINE_BITS-1:0] d_wdata,
    output logic                 d_ack,
    output logic                 d_rvalid,
    output logic [LINE_BITS-1:0] d_rdata,
    output logic                 mem_valid,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic                 mem_ready,
    input  logic                 mem_resp_valid,
    input  logic [LINE_BITS-1:0] mem_rdata,
    output logic                 busy,
    output logic                 proto_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state;
    logic   owner_d;
    logic   grant_i_c;
    logic   grant_d_c;

`ifdef ARB_ROUND_ROBIN_EN
    logic   last_grant_d;
`endif

    // Same-cycle grant while idle; the loser keeps its request up until acked.
    always_comb begin
        grant_i_c = 1'b0;
        grant_d_c = 1'b0;
        if (state == IDLE) begin
            if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (last_grant_d) begin
                    grant_i_c = 1'b1;
                end else begin
                    grant_d_c = 1'b1;
                end
`else
                grant_d_c = 1'b1;
`endif
            end else begin
                grant_i_c = i_req;
                grant_d_c = d_req;
            end
        end
    end

    // Acks are combinational by design; held low while reset is asserted.
    assign i_ack = grant_i_c & reset;
    assign d_ack = grant_d_c & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner_d   <= 1'b1;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rvalid  <= 1'b0;
            i_rdata   <= '0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_d <= 1'b1;
`endif
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;

            // A response with no transaction waiting is a memory-side protocol fault.
            if (mem_resp_valid && (state != WAIT)) begin
                proto_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (grant_i_c || grant_d_c) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        mem_valid <= 1'b1;
                        owner_d   <= grant_d_c;
                        mem_addr  <= grant_d_c ? d_addr : i_addr;
                        mem_we    <= grant_d_c & d_we;
                        mem_wdata <= grant_d_c ? d_wdata : '0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_d <= grant_d_c;
`endif
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        state     <= WAIT;
                        mem_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (owner_d) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= mem_rdata;
                        end else begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    mem_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter: one record per clock cycle of inputs and expected outputs.
// Honours ARB_ROUND_ROBIN_EN when compiled with the same define as the design.
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [127:0] Z  = '0;
    localparam logic [127:0] A5 = {16{8'hA5}};
    localparam logic [127:0] DD = {16{8'hDD}};
    localparam logic [127:0] ON = {16{8'h11}};

    // f: {i_ack, d_ack, mem_valid, i_rvalid, d_rvalid, busy, proto_err}
    typedef struct {
        logic         i_req;
        logic [31:0]  i_addr;
        logic         d_req;
        logic         d_we;
        logic [31:0]  d_addr;
        logic [127:0] d_wdata;
        logic         mem_ready;
        logic         mem_resp_valid;
        logic [127:0] mem_rdata;
        logic [6:0]   f;
        logic         chk_mem;
        logic         e_we;
        logic [31:0]  e_addr;
        logic [127:0] e_wdata;
        logic         chk_ird;
        logic [127:0] e_ird;
        logic         chk_drd;
        logic [127:0] e_drd;
    } vec_t;

    logic         clk, reset;
    logic         i_req, i_ack, i_rvalid;
    logic [31:0]  i_addr;
    logic [127:0] i_rdata;
    logic         d_req, d_we, d_ack, d_rvalid;
    logic [31:0]  d_addr;
    logic [127:0] d_wdata, d_rdata;
    logic         mem_valid, mem_we, mem_ready, mem_resp_valid;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         busy, proto_err;

    int tests = 0;
    int fails = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .busy(busy), .proto_err(proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                                input logic [31:0] da, input logic [127:0] dwd, input logic rdy,
                                input logic rsp, input logic [127:0] rd, input logic [6:0] f);
        vec_t v;
        v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dwd;
        v.mem_ready = rdy; v.mem_resp_valid = rsp; v.mem_rdata = rd; v.f = f;
        v.chk_mem = 1'b0; v.e_we = 1'b0; v.e_addr = '0; v.e_wdata = '0;
        v.chk_ird = 1'b0; v.e_ird = '0; v.chk_drd = 1'b0; v.e_drd = '0;
        return v;
    endfunction

    function automatic vec_t idle(input logic [6:0] f);
        return mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b0, 1'b0, Z, f);
    endfunction

    function automatic vec_t wm(input vec_t v, input logic we, input logic [31:0] a, input logic [127:0] wd);
        vec_t r = v;
        r.chk_mem = 1'b1; r.e_we = we; r.e_addr = a; r.e_wdata = wd;
        return r;
    endfunction

    function automatic vec_t wi(input vec_t v, input logic [127:0] d);
        vec_t r = v;
        r.chk_ird = 1'b1; r.e_ird = d;
        return r;
    endfunction

    function automatic vec_t wd(input vec_t v, input logic [127:0] d);
        vec_t r = v;
        r.chk_drd = 1'b1; r.e_drd = d;
        return r;
    endfunction

    task automatic cmp(input string n, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic check(input vec_t v, input string n);
        cmp({n, ".i_ack"},     128'(i_ack),     128'(v.f[6]));
        cmp({n, ".d_ack"},     128'(d_ack),     128'(v.f[5]));
        cmp({n, ".mem_valid"}, 128'(mem_valid), 128'(v.f[4]));
        cmp({n, ".i_rvalid"},  128'(i_rvalid),  128'(v.f[3]));
        cmp({n, ".d_rvalid"},  128'(d_rvalid),  128'(v.f[2]));
        cmp({n, ".busy"},      128'(busy),      128'(v.f[1]));
        cmp({n, ".proto_err"}, 128'(proto_err), 128'(v.f[0]));
        if (v.chk_mem) begin
            cmp({n, ".mem_we"},    128'(mem_we),   128'(v.e_we));
            cmp({n, ".mem_addr"},  128'(mem_addr), 128'(v.e_addr));
            cmp({n, ".mem_wdata"}, mem_wdata,      v.e_wdata);
        end
        if (v.chk_ird) cmp({n, ".i_rdata"}, i_rdata, v.e_ird);
        if (v.chk_drd) cmp({n, ".d_rdata"}, d_rdata, v.e_drd);
    endtask

    // Drive a cycle's inputs after the falling edge, check before the next rising edge.
    task automatic step(input vec_t v, input string n);
        @(negedge clk);
        i_req = v.i_req; i_addr = v.i_addr;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
        mem_ready = v.mem_ready; mem_resp_valid = v.mem_resp_valid; mem_rdata = v.mem_rdata;
        #2;
        check(v, n);
    endtask

    task automatic run(input vec_t q[$], input string n);
        foreach (q[k]) step(q[k], $sformatf("%s[%0d]", n, k));
    endtask

    vec_t tbl[$];
    vec_t seq[$];
    vec_t v;

    initial begin
        // I-only read, memory ready at once
        tbl.push_back(mk(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, Z, 1'b0, 1'b0, Z, 7'b1000000));
        tbl.push_back(wm(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b1, 1'b0, Z, 7'b0010010), 1'b0, 32'h100, Z));
        tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b0, 1'b1, A5, 7'b0000010));
        tbl.push_back(wi(idle(7'b0001000), A5));
        tbl.push_back(wi(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b1, 1'b0, Z, 7'b0000000), A5));
        // D write, mem_ready held off for two cycles
        tbl.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h2040, 128'h1234, 1'b0, 1'b0, Z, 7'b0100000));
        tbl.push_back(wm(idle(7'b0010010), 1'b1, 32'h2040, 128'h1234));
        tbl.push_back(wm(idle(7'b0010010), 1'b1, 32'h2040, 128'h1234));
        tbl.push_back(wm(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b1, 1'b0, Z, 7'b0010010), 1'b1, 32'h2040, 128'h1234));
        tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b0, 1'b1, ON, 7'b0000010));
        tbl.push_back(idle(7'b0000100));
        tbl.push_back(wi(idle(7'b0000000), A5));
        // Simultaneous requests; the loser holds its request until acked
        tbl.push_back(mk(1'b1, 32'h300, 1'b1, 1'b0, 32'h400, Z, 1'b0, 1'b0, Z, {RR, ~RR, 5'b00000}));
        tbl.push_back(wm(mk(~RR, 32'h300, RR, 1'b0, 32'h400, Z, 1'b1, 1'b0, Z, 7'b0010010),
                         1'b0, RR ? 32'h300 : 32'h400, Z));
        tbl.push_back(mk(~RR, 32'h300, RR, 1'b0, 32'h400, Z, 1'b0, 1'b1, DD, 7'b0000010));
        v = mk(~RR, 32'h300, RR, 1'b0, 32'h400, Z, 1'b0, 1'b0, Z, {~RR, RR, 1'b0, RR, ~RR, 2'b00});
        tbl.push_back(RR ? wi(v, DD) : wd(v, DD));
        tbl.push_back(wm(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b1, 1'b0, Z, 7'b0010010),
                         1'b0, RR ? 32'h400 : 32'h300, Z));
        tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b0, 1'b1, ON, 7'b0000010));
        tbl.push_back(wd(wi(idle({3'b000, ~RR, RR, 2'b00}), RR ? DD : ON), RR ? ON : DD));

        reset = 1'b0;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        #12;
        check(wd(wi(wm(idle(7'b0000000), 1'b0, 32'h0, Z), Z), Z), "reset");
        @(negedge clk);
        reset = 1'b1;

        run(tbl, "tbl");

        // Back-to-back: new D request in the d_rvalid cycle
        seq.delete();
        seq.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, Z, 1'b0, 1'b0, Z, 7'b0100000));
        seq.push_back(wm(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b1, 1'b0, Z, 7'b0010010), 1'b0, 32'h500, Z));
        seq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b0, 1'b1, A5, 7'b0000010));
        seq.push_back(wd(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h600, Z, 1'b0, 1'b0, Z, 7'b0100100), A5));
        seq.push_back(wm(idle(7'b0010010), 1'b0, 32'h600, Z));
        seq.push_back(wm(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b1, 1'b0, Z, 7'b0010010), 1'b0, 32'h600, Z));
        seq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b0, 1'b1, DD, 7'b0000010));
        seq.push_back(wd(idle(7'b0000100), DD));
        run(seq, "b2b");

        // I grant, then a tie in the i_rvalid cycle: D wins in both builds
        seq.delete();
        seq.push_back(mk(1'b1, 32'h700, 1'b0, 1'b0, 32'h0, Z, 1'b0, 1'b0, Z, 7'b1000000));
        seq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b1, 1'b0, Z, 7'b0010010));
        seq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b0, 1'b1, ON, 7'b0000010));
        seq.push_back(wi(mk(1'b1, 32'h800, 1'b1, 1'b0, 32'h900, Z, 1'b0, 1'b0, Z, 7'b0101000), ON));
        seq.push_back(wm(mk(1'b1, 32'h800, 1'b0, 1'b0, 32'h0, Z, 1'b1, 1'b0, Z, 7'b0010010), 1'b0, 32'h900, Z));
        seq.push_back(mk(1'b1, 32'h800, 1'b0, 1'b0, 32'h0, Z, 1'b0, 1'b1, DD, 7'b0000010));
        seq.push_back(wd(mk(1'b1, 32'h800, 1'b0, 1'b0, 32'h0, Z, 1'b0, 1'b0, Z, 7'b1000100), DD));
        seq.push_back(wm(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b1, 1'b0, Z, 7'b0010010), 1'b0, 32'h800, Z));
        seq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b0, 1'b1, A5, 7'b0000010));
        seq.push_back(wi(idle(7'b0001000), A5));
        run(seq, "tie2");

        // Spurious response while idle
        seq.delete();
        seq.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b0, 1'b1, ON, 7'b0000000));
        seq.push_back(wd(wi(idle(7'b0000001), A5), DD));
        seq.push_back(wd(wi(idle(7'b0000001), A5), DD));
        run(seq, "spur");

        // Reset during WAIT, then the abandoned response arrives
        seq.delete();
        seq.push_back(mk(1'b1, 32'hA00, 1'b0, 1'b0, 32'h0, Z, 1'b0, 1'b0, Z, 7'b1000001));
        seq.push_back(wm(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b1, 1'b0, Z, 7'b0010011), 1'b0, 32'hA00, Z));
        seq.push_back(idle(7'b0000011));
        run(seq, "rstpre");
        reset = 1'b0;
        #2;
        check(wd(wi(wm(idle(7'b0000000), 1'b0, 32'h0, Z), Z), Z), "rstmid");
        @(negedge clk);
        reset = 1'b1;
        seq.delete();
        seq.push_back(wd(wi(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, Z, 1'b0, 1'b1, DD, 7'b0000000), Z), Z));
        seq.push_back(wd(wi(idle(7'b0000001), Z), Z));
        seq.push_back(wd(wi(idle(7'b0000001), Z), Z));
        run(seq, "rstpost");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
